servo_pwm_settle_unit: RTL and testbench



---
 rtl/servo_pwm_settle_unit.sv | 194 +++++++++++++++++++
 tb/tb_servo_pwm_settle_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_settle_unit.sv
// servo_pwm_settle_unit: four-channel servo PWM back end with pose-settle handshake.
// A free-running frame counter drives four registered PWM outputs. Angle commands are
// sampled only at frame boundaries. After the pose has been held for SETTLE_FRAMES
// frames, a one-clock rdy pulse is issued.
// Build option: define SERVO_RAMP_EN to slew each channel by at most RAMP_STEP degrees
// per frame instead of jumping straight to the commanded angle.
module servo_pwm_settle_unit #(
  parameter int FRAME_TICKS   = 1000000,
  parameter int MIN_TICKS     = 25000,
  parameter int DEG_TICKS     = 555,
  parameter int SETTLE_FRAMES = 25,
  parameter int RAMP_STEP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] angle1,
  input  logic [7:0] angle2,
  input  logic [7:0] angle3,
  input  logic [7:0] angle4,
  input  logic       t_restart,
  output logic       pwm1,
  output logic       pwm2,
  output logic       pwm3,
  output logic       pwm4,
  output logic       rdy,
  output logic       busy
);

  localparam int CNT_W = $clog2(FRAME_TICKS);
  localparam int SET_W = $clog2(SETTLE_FRAMES + 1);

  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_W       = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] DEG_W       = CNT_W'(DEG_TICKS);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_FRAMES);
  localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);
  localparam logic [7:0]       MAX_DEG     = 8'd180;
`ifdef SERVO_RAMP_EN
  localparam logic [7:0]       RAMP_W      = 8'(RAMP_STEP);
`endif

  // Elaboration-time guard: the widest pulse must fit inside a frame, the settle
  // count must be at least one frame, and the ramp must make progress.
  if ((SETTLE_FRAMES < 1) || (RAMP_STEP < 1) ||
      (MIN_TICKS + 180 * DEG_TICKS >= FRAME_TICKS)) begin : g_cfg_error
    $error("servo_pwm_settle_unit: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  logic [CNT_W-1:0] cnt_reg;
  logic             fb;
  logic [7:0]       angle_arr [4];
  logic [3:0]       chg_vec;
  logic             chg;

  state_t           state_reg;
  logic [SET_W-1:0] settle_reg;
  logic             rdy_reg;
  logic             busy_reg;

  assign fb  = (cnt_reg == FRAME_LAST);
  assign chg = |chg_vec;

  assign angle_arr[0] = angle1;
  assign angle_arr[1] = angle2;
  assign angle_arr[2] = angle3;
  assign angle_arr[3] = angle4;

  // Free-running frame counter, 0..FRAME_TICKS-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (fb) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic [7:0]       tgt;
      logic [7:0]       act_reg;
      logic [7:0]       act_next;
      logic [CNT_W-1:0] width;
      logic             pwm_reg;

      assign tgt = (angle_arr[gi] > MAX_DEG) ? MAX_DEG : angle_arr[gi];

`ifdef SERVO_RAMP_EN
      logic [7:0] gap;

      // Slew the active angle toward the target by at most RAMP_STEP degrees.
      always_comb begin
        gap      = 8'd0;
        act_next = act_reg;
        if (tgt > act_reg) begin
          gap      = tgt - act_reg;
          act_next = act_reg + ((gap > RAMP_W) ? RAMP_W : gap);
        end else if (tgt < act_reg) begin
          gap      = act_reg - tgt;
          act_next = act_reg - ((gap > RAMP_W) ? RAMP_W : gap);
        end
      end

      // Still moving after this frame's step: the pose is not yet held.
      assign chg_vec[gi] = (act_next != tgt);
`else
      assign act_next    = tgt;
      assign chg_vec[gi] = (tgt != act_reg);
`endif

      // Active angle only changes on a frame boundary.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          act_reg <= 8'd0;
        end else if (fb) begin
          act_reg <= act_next;
        end
      end

      // act_reg <= 180 and the parameter guard keep this product below FRAME_TICKS.
      assign width = MIN_W + CNT_W'(act_reg) * DEG_W;

      // Registered PWM compare, one clock behind the counter.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pwm_reg <= 1'b0;
        end else begin
          pwm_reg <= (cnt_reg < width);
        end
      end
    end
  endgenerate

  assign pwm1 = g_ch[0].pwm_reg;
  assign pwm2 = g_ch[1].pwm_reg;
  assign pwm3 = g_ch[2].pwm_reg;
  assign pwm4 = g_ch[3].pwm_reg;

  // Settle sequencer: counts held frames, then emits a single-clock rdy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      settle_reg <= '0;
      rdy_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (fb && (chg || t_restart)) begin
            state_reg  <= ST_SETTLE;
            settle_reg <= SETTLE_LOAD;
            busy_reg   <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (fb) begin
            // A pose change always restarts the hold, even on the last frame.
            if (chg) begin
              settle_reg <= SETTLE_LOAD;
            end else if (settle_reg == SET_ONE) begin
              state_reg <= ST_DONE;
              rdy_reg   <= 1'b1;
            end else begin
              settle_reg <= settle_reg - SET_ONE;
            end
          end
        end
        ST_DONE: begin
          // DONE lasts exactly one clock regardless of the frame position.
          state_reg <= ST_IDLE;
          rdy_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          rdy_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rdy  = rdy_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_servo_pwm_settle_unit.sv
// Testbench for servo_pwm_settle_unit (small frame: 400 clk, 10 + 1/deg, settle 3 frames).
// Each table row describes one frame: the inputs driven during that frame (sampled at its
// closing boundary) and what the frame must show: per-channel pulse width, busy just
// after the opening boundary, and whether rdy fires right after the closing boundary.
module tb_servo_pwm_settle_unit;

  localparam int FT = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] angle1 = 8'd0;
  logic [7:0] angle2 = 8'd0;
  logic [7:0] angle3 = 8'd0;
  logic [7:0] angle4 = 8'd0;
  logic       t_restart = 1'b0;
  logic       pwm1, pwm2, pwm3, pwm4, rdy, busy;

  always #5 clk = ~clk;

  servo_pwm_settle_unit #(
    .FRAME_TICKS  (FT),
    .MIN_TICKS    (10),
    .DEG_TICKS    (1),
    .SETTLE_FRAMES(3),
    .RAMP_STEP    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .angle1   (angle1),
    .angle2   (angle2),
    .angle3   (angle3),
    .angle4   (angle4),
    .t_restart(t_restart),
    .pwm1     (pwm1),
    .pwm2     (pwm2),
    .pwm3     (pwm3),
    .pwm4     (pwm4),
    .rdy      (rdy),
    .busy     (busy)
  );

  typedef struct {
    logic [3:0][7:0] a;
    logic            tr;
    logic            gl;    // drive angle2 = 0 for the first half of the frame
    logic [3:0][8:0] w;
    logic            busy;
    logic            rdy;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  int   hi [4];
  int   rdy_cnt;
  logic rdy_last;
  logic busy_first;

  task automatic add(input int a1, input int a2, input int a3, input int a4,
                     input int tr, input int gl,
                     input int w1, input int w2, input int w3, input int w4,
                     input int b, input int r);
    vec_t v;
    v.a[0] = 8'(a1); v.a[1] = 8'(a2); v.a[2] = 8'(a3); v.a[3] = 8'(a4);
    v.tr   = tr[0];  v.gl   = gl[0];
    v.w[0] = 9'(w1); v.w[1] = 9'(w2); v.w[2] = 9'(w3); v.w[3] = 9'(w4);
    v.busy = b[0];   v.rdy  = r[0];
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Drive one frame's inputs, measure the following 400 clocks, compare against the
  // expectation queued when the stimulus went out.
  task automatic run_frame(input vec_t v, input int f);
    vec_t e;
    angle1    = v.a[0];
    angle2    = v.gl ? 8'd0 : v.a[1];
    angle3    = v.a[2];
    angle4    = v.a[3];
    t_restart = v.tr;
    exp_q.push_back(v);
    for (int i = 0; i < 4; i++) hi[i] = 0;
    rdy_cnt    = 0;
    rdy_last   = 1'b0;
    busy_first = 1'b0;
    for (int p = 1; p <= FT; p++) begin
      @(posedge clk);
      @(negedge clk);
      if (pwm1) hi[0]++;
      if (pwm2) hi[1]++;
      if (pwm3) hi[2]++;
      if (pwm4) hi[3]++;
      if (rdy) rdy_cnt++;
      if (p == 1) busy_first = busy;
      if (p == FT) rdy_last = rdy;
      if (p == FT / 2) angle2 = v.a[1];
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 4; i++)
      check($sformatf("f%0d width%0d", f, i + 1), hi[i], int'(e.w[i]));
    check($sformatf("f%0d busy", f), int'(busy_first), int'(e.busy));
    check($sformatf("f%0d rdy_count", f), rdy_cnt, int'(e.rdy));
    check($sformatf("f%0d rdy_at_boundary", f), int'(rdy_last), int'(e.rdy));
    $display("frame %0d: angles %0d/%0d/%0d/%0d tr=%0b widths %0d/%0d/%0d/%0d busy=%0b rdy=%0d",
             f, v.a[0], v.a[1], v.a[2], v.a[3], v.tr, hi[0], hi[1], hi[2], hi[3],
             busy_first, rdy_cnt);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t z;
    //  a1   a2  a3   a4  tr gl |  w1   w2  w3   w4  busy rdy
    add(  0,  0,  0,   0, 0, 0,   10,  10, 10,  10, 0, 0);  // f0 idle, 0 deg
    add(  0,  0,  0,   0, 0, 0,   10,  10, 10,  10, 0, 0);  // f1
    add(  0, 90,  0,   0, 0, 0,   10,  10, 10,  10, 0, 0);  // f2 angle2 -> 90
    add(  0, 90,  0,   0, 0, 0,   10, 100, 10,  10, 1, 0);  // f3
    add(  0, 90,  0,   0, 0, 0,   10, 100, 10,  10, 1, 0);  // f4
    add(  0, 90,  0,   0, 0, 0,   10, 100, 10,  10, 1, 1);  // f5 rdy after 3rd fb
    add(  0, 90,  0,   0, 0, 1,   10, 100, 10,  10, 0, 0);  // f6 mid-frame glitch ignored
    add(200, 90,  0,   0, 0, 0,   10, 100, 10,  10, 0, 0);  // f7 angle1 200 -> clamp
    add(200, 90,  0,   0, 0, 0,  190, 100, 10,  10, 1, 0);  // f8
    add(200, 90,  0,   0, 0, 0,  190, 100, 10,  10, 1, 0);  // f9
    add(200, 90, 50,   0, 0, 0,  190, 100, 10,  10, 1, 0);  // f10 change on last frame
    add(200, 90, 50,   0, 0, 0,  190, 100, 60,  10, 1, 0);  // f11
    add(200, 90, 50,   0, 0, 0,  190, 100, 60,  10, 1, 0);  // f12
    add(200, 90, 50,   0, 0, 0,  190, 100, 60,  10, 1, 1);  // f13 rdy 3 frames later
    add(200, 90, 50,   0, 1, 0,  190, 100, 60,  10, 0, 0);  // f14 t_restart held
    add(200, 90, 50,   0, 1, 0,  190, 100, 60,  10, 1, 0);  // f15
    add(200, 90, 50,   0, 1, 0,  190, 100, 60,  10, 1, 0);  // f16
    add(200, 90, 50,   0, 1, 0,  190, 100, 60,  10, 1, 1);  // f17
    add(200, 90, 50,   0, 1, 0,  190, 100, 60,  10, 0, 0);  // f18 idle wait, restart
    add(200, 90, 50,   0, 1, 0,  190, 100, 60,  10, 1, 0);  // f19
    add(200, 90, 50,   0, 1, 0,  190, 100, 60,  10, 1, 0);  // f20
    add(200, 90, 50,   0, 1, 0,  190, 100, 60,  10, 1, 1);  // f21
    add(200, 90, 50,   0, 0, 0,  190, 100, 60,  10, 0, 0);  // f22 released, stays idle
    add(180, 90, 50, 181, 0, 0,  190, 100, 60,  10, 0, 0);  // f23 180 unchanged, 181 clamp
    add(180, 90, 50, 181, 1, 0,  190, 100, 60, 190, 1, 0);  // f24 t_restart ignored
    add(180, 90, 50, 181, 1, 0,  190, 100, 60, 190, 1, 0);  // f25
    add(180, 90, 50, 181, 0, 0,  190, 100, 60, 190, 1, 1);  // f26
    add(180, 90, 50, 181, 0, 0,  190, 100, 60, 190, 0, 0);  // f27
    add(  0,  0,  0,   0, 0, 0,  190, 100, 60, 190, 0, 0);  // f28 enters SETTLE

    // Held in reset: all outputs low.
    repeat (3) @(negedge clk);
    check("reset pwm1", int'(pwm1), 0);
    check("reset pwm2", int'(pwm2), 0);
    check("reset pwm3", int'(pwm3), 0);
    check("reset pwm4", int'(pwm4), 0);
    check("reset rdy", int'(rdy), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b1;

    for (int f = 0; f < tbl.size(); f++) run_frame(tbl[f], f);

    // Reset in the middle of SETTLE while the pulses are high.
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre-reset busy", int'(busy), 1);
    check("pre-reset pwm1", int'(pwm1), 1);
    rst = 1'b0;
    #1;
    check("mid-reset pwm1", int'(pwm1), 0);
    check("mid-reset pwm2", int'(pwm2), 0);
    check("mid-reset pwm3", int'(pwm3), 0);
    check("mid-reset pwm4", int'(pwm4), 0);
    check("mid-reset rdy", int'(rdy), 0);
    check("mid-reset busy", int'(busy), 0);
    $display("reset asserted mid-settle: pwm=%0b%0b%0b%0b busy=%0b rdy=%0b",
             pwm1, pwm2, pwm3, pwm4, busy, rdy);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // After release: same as power-up, and no rdy for the aborted settle.
    z.a = '0; z.tr = 1'b0; z.gl = 1'b0;
    for (int i = 0; i < 4; i++) z.w[i] = 9'd10;
    z.busy = 1'b0; z.rdy = 1'b0;
    for (int f = 0; f < 5; f++) run_frame(z, 100 + f);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
